// File: rtl/dmem_arbiter_if.sv
// Core-side and memory-side signal bundle for dmem_arbiter.
// slave is the arbiter's view; master is the cores-plus-memory environment's view.
interface dmem_arbiter_if #(
    parameter int unsigned num_req_p    = 4,
    parameter int unsigned addr_width_p = 32
);
    logic [num_req_p-1:0]              req_valid_i;
    logic [num_req_p-1:0]              req_wen_i;
    logic [num_req_p-1:0]              req_byte_i;
    logic [num_req_p*addr_width_p-1:0] req_addr_i;
    logic [num_req_p*32-1:0]           req_wdata_i;
    logic [num_req_p-1:0]              req_yumi_o;
    logic [num_req_p-1:0]              resp_valid_o;
    logic [31:0]                       resp_rdata_o;
    logic [num_req_p-1:0]              resp_yumi_i;

    logic                              mem_valid_o;
    logic                              mem_wen_o;
    logic                              mem_byte_o;
    logic [addr_width_p-1:0]           mem_addr_o;
    logic [31:0]                       mem_wdata_o;
    logic                              mem_yumi_i;
    logic                              mem_rvalid_i;
    logic [31:0]                       mem_rdata_i;
    logic                              mem_ryumi_o;

    modport slave (
        input  req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, resp_yumi_i,
        input  mem_yumi_i, mem_rvalid_i, mem_rdata_i,
        output req_yumi_o, resp_valid_o, resp_rdata_o,
        output mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, mem_ryumi_o
    );

    modport master (
        output req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, resp_yumi_i,
        output mem_yumi_i, mem_rvalid_i, mem_rdata_i,
        input  req_yumi_o, resp_valid_o, resp_rdata_o,
        input  mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, mem_ryumi_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among num_req_p cores, one transaction at a time.
// Optional watchdog enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
    parameter int unsigned num_req_p    = 4,
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned timeout_p    = 255,
    localparam int unsigned gw          = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus,
    output logic [gw-1:0] grant_id_o,
    output logic          busy_o,
    output logic          timeout_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

    state_e                  state_q, state_d;
    logic [gw-1:0]           last_q;
    logic [gw-1:0]           grant_q;
    logic                    wen_q;
    logic                    byte_q;
    logic [addr_width_p-1:0] addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;

    logic                    found;
    logic [gw-1:0]           pick;
    logic                    to_fire;

    // Search starts just after the last winner; the wrap is explicit so num_req_p may be any value.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= num_req_p; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            if (!found && bus.req_valid_i[gw'(idx)]) begin
                found = 1'b1;
                pick  = gw'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.mem_yumi_i) begin
                    state_d = bus.mem_rvalid_i ? StDeliver : StWait;
                end else if (to_fire) begin
                    state_d = StDeliver;
                end
            end
            StWait: begin
                if (bus.mem_rvalid_i || to_fire) begin
                    state_d = StDeliver;
                end
            end
            StDeliver: begin
                if (bus.resp_yumi_i[grant_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_yumi_o   = '0;
        bus.resp_valid_o = '0;
        bus.mem_valid_o  = 1'b0;
        bus.mem_wen_o    = 1'b0;
        bus.mem_byte_o   = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_wdata_o  = '0;
        bus.mem_ryumi_o  = 1'b0;
        case (state_q)
            StIssue: begin
                bus.mem_valid_o = 1'b1;
                bus.mem_wen_o   = wen_q;
                bus.mem_byte_o  = byte_q;
                bus.mem_addr_o  = addr_q;
                bus.mem_wdata_o = wdata_q;
                // A watchdog expiry still completes the core's request handshake.
                if (bus.mem_yumi_i || to_fire) begin
                    bus.req_yumi_o[grant_q] = 1'b1;
                end
                if (bus.mem_yumi_i && bus.mem_rvalid_i) begin
                    bus.mem_ryumi_o = 1'b1;
                end
            end
            StWait: begin
                if (bus.mem_rvalid_i) begin
                    bus.mem_ryumi_o = 1'b1;
                end
            end
            StDeliver: begin
                bus.resp_valid_o[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.resp_rdata_o = rdata_q;
    assign busy_o           = (state_q != StIdle);
    assign grant_id_o       = grant_q;

    // Request fields are frozen at grant time so the core may change them while waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q  <= gw'(num_req_p - 1);
            grant_q <= '0;
            wen_q   <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == StIdle && found) begin
                grant_q <= pick;
                wen_q   <= bus.req_wen_i[pick];
                byte_q  <= bus.req_byte_i[pick];
                addr_q  <= bus.req_addr_i[32'(pick) * addr_width_p +: addr_width_p];
                wdata_q <= bus.req_wdata_i[32'(pick) * 32 +: 32];
            end
            if (bus.mem_ryumi_o) begin
                rdata_q <= bus.mem_rdata_i;
            end else if (to_fire) begin
                rdata_q <= 32'hDEAD_BEEF;
            end
            if (state_q == StDeliver && state_d == StIdle) begin
                last_q <= grant_q;
            end
        end
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int unsigned cw = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;

    logic [cw-1:0] cnt_q;
    logic          timeout_q;

    assign to_fire   = (state_q == StIssue || state_q == StWait) && (cnt_q == cw'(timeout_p));
    assign timeout_o = timeout_q;

    // IDLE always precedes ISSUE, so clearing there restarts the count for every grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                cnt_q <= '0;
            end else if (state_q == StIssue || state_q == StWait) begin
                cnt_q <= cnt_q + cw'(1);
            end
            if (to_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign to_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with hand-computed expectations.
// The watchdog section follows DMEM_ARB_TIMEOUT_EN.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         exp_g [5] = '{0, 1, 2, 3, 0};

    dmem_arbiter_if #(.num_req_p(4), .addr_width_p(32)) bus ();

    dmem_arbiter #(
        .num_req_p   (4),
        .addr_width_p(32),
        .timeout_p   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .grant_id_o(grant_id),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_inputs();
        bus.req_valid_i  = '0;
        bus.req_wen_i    = '0;
        bus.req_byte_i   = '0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.resp_yumi_i  = '0;
        bus.mem_yumi_i   = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic set_req(input int c, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.req_wen_i[c]             = wen;
        bus.req_addr_i[c*32 +: 32]  = addr;
        bus.req_wdata_i[c*32 +: 32] = wdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_mem_valid", 32'(bus.mem_valid_o), 0);
        check("rst_req_yumi", 32'(bus.req_yumi_o), 0);
        check("rst_resp_valid", 32'(bus.resp_valid_o), 0);
        check("rst_rdata", bus.resp_rdata_o, 0);
        check("rst_timeout", 32'(timeout), 0);
        reset = 1'b0;

        // Single load from core 2
        bus.req_valid_i = 4'b0100;
        set_req(2, 1'b0, 32'h40, 32'h0);
        settle();
        check("t1_idle_mem_valid", 32'(bus.mem_valid_o), 0);
        tick();
        bus.mem_yumi_i = 1'b1;
        settle();
        check("t1_mem_valid", 32'(bus.mem_valid_o), 1);
        check("t1_mem_addr", bus.mem_addr_o, 32'h40);
        check("t1_mem_wen", 32'(bus.mem_wen_o), 0);
        check("t1_req_yumi", 32'(bus.req_yumi_o), 32'b0100);
        check("t1_grant", 32'(grant_id), 2);
        check("t1_ryumi_issue", 32'(bus.mem_ryumi_o), 0);
        tick();
        bus.req_valid_i = '0;
        bus.mem_yumi_i  = 1'b0;
        settle();
        check("t1_wait_req_yumi", 32'(bus.req_yumi_o), 0);
        check("t1_wait_mem_valid", 32'(bus.mem_valid_o), 0);
        check("t1_wait_busy", 32'(busy), 1);
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1234_5678;
        settle();
        check("t1_ryumi", 32'(bus.mem_ryumi_o), 1);
        check("t1_resp_early", 32'(bus.resp_valid_o), 0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        bus.resp_yumi_i  = 4'b0001;
        settle();
        check("t1_resp_valid", 32'(bus.resp_valid_o), 32'b0100);
        check("t1_resp_rdata", bus.resp_rdata_o, 32'h1234_5678);
        check("t1_deliver_ryumi", 32'(bus.mem_ryumi_o), 0);
        tick();
        bus.resp_yumi_i = 4'b0100;
        settle();
        check("t1_foreign_yumi_ignored", 32'(bus.resp_valid_o), 32'b0100);
        tick();
        bus.resp_yumi_i = '0;
        settle();
        check("t1_release_busy", 32'(busy), 0);
        check("t1_grant_held", 32'(grant_id), 2);
        check("t1_release_resp", 32'(bus.resp_valid_o), 0);

        // Round robin with all cores requesting and an immediate memory
        do_reset();
        bus.req_valid_i  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'(i), 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        end
        bus.mem_yumi_i   = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.resp_yumi_i  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("t2_idle_mem_valid", 32'(bus.mem_valid_o), 0);
            check("t2_idle_ryumi", 32'(bus.mem_ryumi_o), 0);
            tick();
            bus.mem_rdata_i = 32'hC0DE_0000 + 32'(k);
            settle();
            check("t2_grant", 32'(grant_id), 32'(exp_g[k]));
            check("t2_req_yumi", 32'(bus.req_yumi_o), 32'(1) << exp_g[k]);
            check("t2_mem_addr", bus.mem_addr_o, 32'h100 + 32'(4 * exp_g[k]));
            check("t2_mem_wdata", bus.mem_wdata_o, 32'hA0 + 32'(exp_g[k]));
            check("t2_mem_wen", 32'(bus.mem_wen_o), 32'(exp_g[k] % 2));
            check("t2_ryumi", 32'(bus.mem_ryumi_o), 1);
            tick();
            bus.mem_rdata_i = 32'hFFFF_FFFF;
            settle();
            check("t2_resp_valid", 32'(bus.resp_valid_o), 32'(1) << exp_g[k]);
            check("t2_resp_rdata", bus.resp_rdata_o, 32'hC0DE_0000 + 32'(k));
            check("t2_deliver_mem_valid", 32'(bus.mem_valid_o), 0);
            check("t2_deliver_ryumi", 32'(bus.mem_ryumi_o), 0);
            tick();
        end

        // Core 1 holds its response while core 3 waits
        do_reset();
        bus.req_valid_i  = 4'b0010;
        bus.mem_yumi_i   = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h55;
        settle();
        tick();
        bus.req_valid_i = 4'b1000;
        set_req(3, 1'b1, 32'h300, 32'h33);
        settle();
        check("t3_grant1", 32'(grant_id), 1);
        check("t3_req_yumi1", 32'(bus.req_yumi_o), 32'b0010);
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t3_hold_mem_valid", 32'(bus.mem_valid_o), 0);
            check("t3_hold_resp", 32'(bus.resp_valid_o), 32'b0010);
            tick();
        end
        bus.resp_yumi_i = 4'b0010;
        settle();
        check("t3_release_resp", 32'(bus.resp_valid_o), 32'b0010);
        tick();
        bus.resp_yumi_i = '0;
        settle();
        check("t3_idle_mem_valid", 32'(bus.mem_valid_o), 0);
        check("t3_idle_busy", 32'(busy), 0);
        tick();
        settle();
        check("t3_grant3", 32'(grant_id), 3);
        check("t3_mem_valid3", 32'(bus.mem_valid_o), 1);
        check("t3_mem_addr3", bus.mem_addr_o, 32'h300);
        check("t3_mem_wen3", 32'(bus.mem_wen_o), 1);
        check("t3_req_yumi3", 32'(bus.req_yumi_o), 32'b1000);
        bus.req_valid_i = '0;
        tick();
        bus.resp_yumi_i = 4'b1000;
        settle();
        check("t3_resp3", 32'(bus.resp_valid_o), 32'b1000);
        tick();

        // Reset asserted while waiting for the memory response
        do_reset();
        bus.req_valid_i = 4'b0100;
        set_req(2, 1'b0, 32'h80, 32'h0);
        settle();
        tick();
        bus.mem_yumi_i  = 1'b1;
        bus.req_valid_i = '0;
        settle();
        tick();
        bus.mem_yumi_i = 1'b0;
        settle();
        check("t4_wait_busy", 32'(busy), 1);
        check("t4_wait_grant", 32'(grant_id), 2);
        #1;
        reset            = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        #1;
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_grant", 32'(grant_id), 0);
        check("t4_rst_ryumi", 32'(bus.mem_ryumi_o), 0);
        check("t4_rst_resp", 32'(bus.resp_valid_o), 0);
        tick();
        reset            = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_yumi_i   = 1'b1;
        bus.req_valid_i  = 4'b1111;
        settle();
        tick();
        settle();
        check("t4_first_grant", 32'(grant_id), 0);
        check("t4_first_req_yumi", 32'(bus.req_yumi_o), 32'b0001);

        // Memory never accepts
        do_reset();
        bus.req_valid_i = 4'b0010;
        set_req(1, 1'b0, 32'h44, 32'h0);
        settle();
        tick();
        bus.req_valid_i = '0;
`ifdef DMEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            settle();
            check("t5_pending_req_yumi", 32'(bus.req_yumi_o), 0);
            tick();
        end
        settle();
        check("t5_fire_req_yumi", 32'(bus.req_yumi_o), 32'b0010);
        check("t5_fire_mem_valid", 32'(bus.mem_valid_o), 1);
        check("t5_fire_not_yet_flag", 32'(timeout), 0);
        tick();
        bus.resp_yumi_i = 4'b0010;
        settle();
        check("t5_resp_valid", 32'(bus.resp_valid_o), 32'b0010);
        check("t5_resp_rdata", bus.resp_rdata_o, 32'hDEAD_BEEF);
        check("t5_flag", 32'(timeout), 1);
        tick();
        bus.resp_yumi_i = '0;
        settle();
        check("t5_idle_busy", 32'(busy), 0);
        check("t5_flag_sticky", 32'(timeout), 1);
        do_reset();
        settle();
        check("t5_flag_cleared", 32'(timeout), 0);
`else
        for (int i = 0; i < 12; i++) begin
            settle();
            check("t5_hang_mem_valid", 32'(bus.mem_valid_o), 1);
            check("t5_hang_req_yumi", 32'(bus.req_yumi_o), 0);
            check("t5_hang_timeout", 32'(timeout), 0);
            tick();
        end
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one data-memory port among num_req_p cores' load/store units using the core's valid/yumi request-response handshake.
- Round-robin grant with one transaction outstanding at a time; the full request→accept→response→release sequence completes before the next grant.
- Sits between the cores' data-memory ports and the single data_mem instance.

Parameters:
- num_req_p, 4, number of requesting cores (≥2, need not be a power of 2)
- addr_width_p, 32, data-memory address width
- timeout_p, 255, watchdog limit in cycles (used only with DMEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid_i  in  num_req_p  per-core request valid
- req_wen_i  in  num_req_p  per-core store (1) / load (0)
- req_byte_i  in  num_req_p  per-core byte_not_word
- req_addr_i  in  num_req_p*addr_width_p  per-core address, core i at slice [i*addr_width_p +: addr_width_p]
- req_wdata_i  in  num_req_p*32  per-core write data, slice i
- req_yumi_o  out  num_req_p  one-cycle pulse: request accepted by memory
- resp_valid_o  out  num_req_p  response valid, one-hot to granted core
- resp_rdata_o  out  32  response data, broadcast to all cores
- resp_yumi_i  in  num_req_p  core consumed response
- mem_valid_o, mem_wen_o, mem_byte_o  out  1 each  downstream request
- mem_addr_o  out  addr_width_p  downstream address
- mem_wdata_o  out  32  downstream write data
- mem_yumi_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory read data
- mem_ryumi_o  out  1  response acknowledge to memory
- grant_id_o  out  $clog2(num_req_p)  current or last granted core
- busy_o  out  1  state != IDLE
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (async, any state):
  - state = IDLE; all outputs 0.
  - Priority pointer last_r = num_req_p-1, so core 0 has highest priority first.
  - Latched request fields cleared.
- States: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - Search req_valid_i starting at last_r+1, wrapping modulo num_req_p (explicit wrap for non-power-of-2).
  - On first hit g: latch g into grant_r and latch that core's wen/byte/addr/wdata; next state ISSUE.
  - No valid: stay IDLE.
- ISSUE:
  - mem_valid_o=1; mem_* driven from latched fields. Later changes or drops of req_*[g] are ignored.
  - On mem_yumi_i: req_yumi_o[g]=1 for exactly this cycle; next state WAIT.
  - If mem_rvalid_i is also high in that cycle, treat as WAIT's rvalid: capture data, assert mem_ryumi_o, go directly to DELIVER.
- WAIT:
  - On mem_rvalid_i: capture mem_rdata_i into rdata_r; mem_ryumi_o=1 in the same cycle; next state DELIVER.
- DELIVER:
  - resp_valid_o[g]=1 and resp_rdata_o=rdata_r. Stores also get a response, with rdata = mem_rdata_i as returned.
  - On resp_yumi_i[g]: last_r<=g; next state IDLE.
  - resp_yumi_i on any other bit is ignored.
- Latency: request seen in cycle 0 → mem_valid_o in cycle 1. Minimum turnaround is 3 cycles to return to IDLE (yumi+rvalid in cycle 1, resp_yumi in cycle 2).
- Fairness: a core that keeps req_valid_i high is granted within num_req_p transactions.
- mem_valid_o is never high outside ISSUE; mem_ryumi_o is never high outside WAIT/ISSUE.
- grant_id_o = grant_r, holding its value after return to IDLE.

Optional Feature:
- Macro DMEM_ARB_TIMEOUT_EN, defined:
  - A cycle counter runs in ISSUE and WAIT and is cleared on entering ISSUE.
  - When it reaches timeout_p, timeout_o sets (sticky until reset) and state goes to DELIVER with rdata_r = 32'hDEAD_BEEF.
  - If the timeout fires in ISSUE, req_yumi_o[g] pulses in that cycle so the core's handshake completes.
  - Late mem_rvalid_i in IDLE or DELIVER gets mem_ryumi_o=0 and is ignored.
- Macro not defined:
  - No counter; timeout_o tied 0; arbiter waits indefinitely; timeout_p unused.

Test Plan:
- Single load: core 2 valid, addr 0x40, mem yumi in cycle 1, rvalid in cycle 3 with data 0x1234_5678 → req_yumi_o=4'b0100 in cycle 1; resp_valid_o=4'b0100 with rdata 0x12345678 from cycle 4.
- Round-robin: all 4 cores valid continuously, memory responds immediately → grant order 0,1,2,3,0.
- Core 1 delays resp_yumi 5 cycles while core 3 is valid → no mem_valid_o until core 1 releases; then core 3 is granted.
- Same-cycle yumi+rvalid in ISSUE → one mem_ryumi_o pulse, DELIVER in the next cycle; no double capture.
- Assert reset in WAIT → all outputs 0 immediately; first grant afterwards goes to core 0.
- With DMEM_ARB_TIMEOUT_EN, timeout_p=8, memory never yumis → req_yumi pulse at ISSUE+8; resp data 0xDEADBEEF; timeout_o stays 1 until reset.
